// File: rtl/ats21_alarm_event_queue.sv
// ats21_alarm_event_queue: edge-detects alarm bits into sticky pending flags and queues them lowest-index-first as {id, timestamp} events
module ats21_alarm_event_queue #(
  parameter int NUM_ALARMS = 24,
  parameter int ID_W = 5,
  parameter int DEPTH = 8,
  parameter int TS_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ALARMS-1:0]      alarm_data,
  input  logic                       enable,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [ID_W-1:0]            evt_id,
  output logic [TS_W-1:0]            evt_time,
  output logic [NUM_ALARMS-1:0]      pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [NUM_ALARMS-1:0] alarm_q, rise, push_sel, merge;
  logic [TS_W-1:0] ts;
  logic [ID_W-1:0] push_id;
  logic [ID_W-1:0] id_mem [DEPTH];
  logic [TS_W-1:0] time_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign rise = alarm_data & ~alarm_q & {NUM_ALARMS{enable}};
  assign evt_valid = count != '0;
  assign pop = evt_valid & evt_ready;
  assign push = |pending && (count < CW'(DEPTH) || pop);
  assign push_sel = push ? pending & (~pending + 1'b1) : '0;
  assign merge = rise & pending & ~push_sel;
  assign evt_id = evt_valid ? id_mem[rd_ptr] : '0;
  assign evt_time = evt_valid ? time_mem[rd_ptr] : '0;
  // Index of the lowest pending bit; it is the one queued next.
  always_comb begin
    push_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (pending[i]) push_id = ID_W'(i);
  end
  // Edge history, timestamp, pending flags, overflow and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q  <= '1;
      ts       <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      alarm_q  <= alarm_data;
      ts       <= ts + 1'b1;
      pending  <= (pending & ~push_sel) | rise;
      overflow <= |merge | (overflow & ~clr_overflow);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
    end
  end
  // Event storage; contents are only visible through evt_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= push_id;
      time_mem[wr_ptr] <= ts;
    end
  end
endmodule
